// File: rtl/hazard_tnew_tracker.sv
// Producer-side Tnew/A3 tracker for the E, M and W stages: D-stage stall and forwarding-ready flags.
// Optional stall counter enabled by defining HAZARD_STALL_CNT_EN.
module hazard_tnew_tracker (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_a1,
    input  logic [4:0]  d_a2,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic [4:0]  d_a3,
    input  logic [1:0]  d_tnew,
    output logic        stall,
    output logic [4:0]  e_a3,
    output logic [4:0]  m_a3,
    output logic [4:0]  w_a3,
    output logic [1:0]  e_tnew,
    output logic [1:0]  m_tnew,
    output logic        e_ready,
    output logic        m_ready,
    output logic [31:0] stall_cnt
);

    logic [4:0] e_a3_q, m_a3_q, w_a3_q;
    logic [1:0] e_tnew_q, m_tnew_q;
    logic       stall_rs, stall_rt;

    // A read of $0 or a non-read (tuse == 3) can never be a hazard.
    always_comb begin
        stall_rs = (d_a1 != 5'd0) && (d_tuse_rs != 2'd3) &&
                   (((d_a1 == e_a3_q) && (e_tnew_q > d_tuse_rs)) ||
                    ((d_a1 == m_a3_q) && (m_tnew_q > d_tuse_rs)));
        stall_rt = (d_a2 != 5'd0) && (d_tuse_rt != 2'd3) &&
                   (((d_a2 == e_a3_q) && (e_tnew_q > d_tuse_rt)) ||
                    ((d_a2 == m_a3_q) && (m_tnew_q > d_tuse_rt)));
        stall    = stall_rs || stall_rt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_a3_q   <= 5'd0;
            e_tnew_q <= 2'd0;
            m_a3_q   <= 5'd0;
            m_tnew_q <= 2'd0;
            w_a3_q   <= 5'd0;
        end else begin
            e_a3_q   <= stall ? 5'd0 : d_a3;
            e_tnew_q <= stall ? 2'd0 : d_tnew;
            m_a3_q   <= e_a3_q;
            m_tnew_q <= (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
            w_a3_q   <= m_a3_q;
        end
    end

    assign e_a3    = e_a3_q;
    assign m_a3    = m_a3_q;
    assign w_a3    = w_a3_q;
    assign e_tnew  = e_tnew_q;
    assign m_tnew  = m_tnew_q;
    assign e_ready = (e_a3_q != 5'd0) && (e_tnew_q == 2'd0);
    assign m_ready = (m_a3_q != 5'd0) && (m_tnew_q == 2'd0);

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_tnew_tracker.sv
// Randomized and directed bench for hazard_tnew_tracker against an age-based pipeline model.
module tb_hazard_tnew_tracker;

    logic        clk;
    logic        reset;
    logic [4:0]  d_a1, d_a2, d_a3;
    logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
    logic        stall;
    logic [4:0]  e_a3, m_a3, w_a3;
    logic [1:0]  e_tnew, m_tnew;
    logic        e_ready, m_ready;
    logic [31:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    hazard_tnew_tracker dut (
        .clk       (clk),
        .reset     (reset),
        .d_a1      (d_a1),
        .d_a2      (d_a2),
        .d_tuse_rs (d_tuse_rs),
        .d_tuse_rt (d_tuse_rt),
        .d_a3      (d_a3),
        .d_tnew    (d_tnew),
        .stall     (stall),
        .e_a3      (e_a3),
        .m_a3      (m_a3),
        .w_a3      (w_a3),
        .e_tnew    (e_tnew),
        .m_tnew    (m_tnew),
        .e_ready   (e_ready),
        .m_ready   (m_ready),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each stage holds the instruction's dest and its Tnew on entry to E;
    // remaining latency is that value minus the number of stages travelled, floored at 0.
    int unsigned mdl_a3 [3];
    int          mdl_tn [3];
    int unsigned mdl_cnt;

    function automatic int remaining(input int s);
        int r;
        r = mdl_tn[s] - s;
        return (r < 0) ? 0 : r;
    endfunction

    function automatic bit hazard(input int unsigned a, input int tuse);
        bit h;
        h = 1'b0;
        if (a != 0 && tuse != 3) begin
            for (int s = 0; s < 2; s++) begin
                if (mdl_a3[s] == a && remaining(s) > tuse) h = 1'b1;
            end
        end
        return h;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 3; s++) begin
            mdl_a3[s] = 0;
            mdl_tn[s] = 0;
        end
        mdl_cnt = 0;
    endtask

    task automatic step(input logic [4:0] a1, input logic [4:0] a2, input logic [1:0] tr,
                        input logic [1:0] tt, input logic [4:0] a3, input logic [1:0] tn,
                        input logic rst, output logic st);
        bit exp_st;
        @(negedge clk);
        d_a1 = a1; d_a2 = a2; d_tuse_rs = tr; d_tuse_rt = tt;
        d_a3 = a3; d_tnew = tn; reset = rst;
        #1;
        exp_st = hazard(a1, tr) || hazard(a2, tt);
        check_eq("stall",   32'(stall),   32'(exp_st));
        check_eq("e_a3",    32'(e_a3),    mdl_a3[0]);
        check_eq("m_a3",    32'(m_a3),    mdl_a3[1]);
        check_eq("w_a3",    32'(w_a3),    mdl_a3[2]);
        check_eq("e_tnew",  32'(e_tnew),  32'(remaining(0)));
        check_eq("m_tnew",  32'(m_tnew),  32'(remaining(1)));
        check_eq("e_ready", 32'(e_ready), 32'(mdl_a3[0] != 0 && remaining(0) == 0));
        check_eq("m_ready", 32'(m_ready), 32'(mdl_a3[1] != 0 && remaining(1) == 0));
`ifdef HAZARD_STALL_CNT_EN
        check_eq("stall_cnt", stall_cnt, mdl_cnt);
`else
        check_eq("stall_cnt", stall_cnt, 32'd0);
`endif
        st = stall;
        if (rst) begin
            model_clear();
        end else begin
            mdl_a3[2] = mdl_a3[1];
            mdl_a3[1] = mdl_a3[0];
            mdl_tn[2] = mdl_tn[1];
            mdl_tn[1] = mdl_tn[0];
            mdl_a3[0] = exp_st ? 0 : int'(a3);
            mdl_tn[0] = exp_st ? 0 : int'(tn);
            if (exp_st) mdl_cnt++;
        end
    endtask

    logic st;

    initial begin
        reset = 1'b1;
        d_a1 = '0; d_a2 = '0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; d_a3 = '0; d_tnew = '0;
        model_clear();
        repeat (2) @(posedge clk);

        // lw $8 -> addu rs=$8 (E use): one stall
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2, 1'b0, st);
        step(5'd8, 5'd0, 2'd1, 2'd3, 5'd9, 2'd1, 1'b0, st);
        check_eq("lwuse_s1", 32'(st), 32'd1);
        step(5'd8, 5'd0, 2'd1, 2'd3, 5'd9, 2'd1, 1'b0, st);
        check_eq("lwuse_s2", 32'(st), 32'd0);
        check_eq("lwuse_m8", 32'(m_a3), 32'd8);

        // lw $8 -> beq $8,$9: two stalls
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2, 1'b0, st);
        step(5'd8, 5'd9, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, st);
        check_eq("lwbeq_s1", 32'(st), 32'd1);
        step(5'd8, 5'd9, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, st);
        check_eq("lwbeq_s2", 32'(st), 32'd1);
        step(5'd8, 5'd9, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, st);
        check_eq("lwbeq_s3", 32'(st), 32'd0);

        // addu $3 -> beq rt=$3: one stall, then M ready
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd1, 1'b0, st);
        step(5'd0, 5'd3, 2'd3, 2'd0, 5'd0, 2'd0, 1'b0, st);
        check_eq("addbeq_s1", 32'(st), 32'd1);
        step(5'd0, 5'd3, 2'd3, 2'd0, 5'd0, 2'd0, 1'b0, st);
        check_eq("addbeq_s2", 32'(st), 32'd0);
        check_eq("addbeq_mr", 32'(m_ready), 32'd1);

        // $0 never hazards; tuse=3 never hazards
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2, 1'b0, st);
        step(5'd0, 5'd0, 2'd1, 2'd0, 5'd0, 2'd0, 1'b0, st);
        check_eq("r0_stall", 32'(st), 32'd0);
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd2, 1'b0, st);
        step(5'd5, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, st);
        check_eq("nread_stall", 32'(st), 32'd0);

        // Reset during first lw->beq stall cycle
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2, 1'b0, st);
        step(5'd8, 5'd9, 2'd0, 2'd0, 5'd0, 2'd0, 1'b1, st);
        check_eq("rst_mid_s", 32'(st), 32'd1);
        step(5'd8, 5'd9, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, st);
        check_eq("rst_after_s", 32'(st), 32'd0);
        check_eq("rst_after_e", 32'(e_a3), 32'd0);
        check_eq("rst_after_cnt", stall_cnt, 32'd0);

        // Three lw->beq pairs from reset
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, st);
        for (int p = 0; p < 3; p++) begin
            step(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2, 1'b0, st);
            repeat (3) step(5'd8, 5'd9, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, st);
        end
        @(negedge clk);
        #1;
`ifdef HAZARD_STALL_CNT_EN
        check_eq("cnt_pairs", stall_cnt, 32'd6);
`else
        check_eq("cnt_pairs", stall_cnt, 32'd0);
`endif

        // Randomized traffic on a small register set to provoke matches
        for (int i = 0; i < 500; i++) begin
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                 ($urandom_range(0, 49) == 0), st);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
